// File: rtl/fm_demodulator_pkg.sv
// Shared constants and constant functions for the FM demodulator: log2/clog2 helpers,
// the CORDIC arctangent table (2^WIDTH = 2*pi) and the CORDIC gain.
package fm_demodulator_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_FS_IN       = 4800000;
  localparam int DEF_FS_OUT      = 48000;
  localparam int DEF_FC_IN       = 1000000;
  localparam int DEF_K           = 200000;
  localparam int DEF_SQUELCH_THR = 1000;

  // CORDIC vectoring gain, 1.646760 in Q16; magnitudes come out scaled by this
  localparam longint CORDIC_GAIN_Q16 = 107922;

  function automatic int log2_floor(input longint v);
    int     r;
    longint t;
    r = 0;
    t = v;
    while (t > 1) begin
      t = t >> 1;
      r++;
    end
    return r;
  endfunction

  function automatic int clog2_ceil(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // atan(2^-i) scaled so that 2^32 = 2*pi
  function automatic longint atan_q32(input int i);
    case (i)
      0:       return 64'd536870912;
      1:       return 64'd316933406;
      2:       return 64'd167458907;
      3:       return 64'd85004756;
      4:       return 64'd42667331;
      5:       return 64'd21354465;
      6:       return 64'd10679838;
      7:       return 64'd5340245;
      8:       return 64'd2670163;
      9:       return 64'd1335087;
      10:      return 64'd667544;
      11:      return 64'd333772;
      12:      return 64'd166886;
      13:      return 64'd83443;
      14:      return 64'd41722;
      15:      return 64'd20861;
      default: return 64'd683565276 >> i;
    endcase
  endfunction

  // Rounded rescale of the Q32 table to a phase word of the given width (width < 32)
  function automatic longint atan_lut(input int i, input int width);
    return (atan_q32(i) + (64'sd1 <<< (31 - width))) >>> (32 - width);
  endfunction

endpackage

// File: rtl/fm_demodulator_cordic_vector.sv
// Pipelined vectoring CORDIC: quadrant pre-rotation, ITER micro-rotations and an output
// register. Returns phase (mod 2^WIDTH) and magnitude (CORDIC-gain scaled), latency ITER+2.
module cordic_vector
  import fm_demodulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] xi,
  input  logic signed [WIDTH-1:0] yi,
  input  logic                    stb_in,
  output logic        [WIDTH-1:0] zo,
  output logic        [WIDTH+1:0] mag,
  output logic                    stb_out
);

  // Two guard bits: one for negating -2^(W-1), one for the ~1.65 CORDIC growth
  localparam int XW = WIDTH + 2;
  localparam logic [WIDTH-1:0] PI = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [XW-1:0]    x_q [0:ITER];
  logic signed [XW-1:0]    y_q [0:ITER-1];
  logic        [WIDTH-1:0] z_q [0:ITER];
  logic        [ITER:0]    vld_q;

  // NOTE: datapath registers carry no reset; only the valid bits do, and they alone decide
  // whether a stage holds a real sample, so the wide pipeline stays reset-free.
  always_ff @(posedge clk) begin
    x_q[0] <= xi[WIDTH-1] ? -XW'(xi) : XW'(xi);
    y_q[0] <= xi[WIDTH-1] ? -XW'(yi) : XW'(yi);
    z_q[0] <= xi[WIDTH-1] ? PI : '0;
    for (int i = 0; i < ITER; i++) begin
      if (!y_q[i][XW-1]) begin
        x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
        z_q[i+1] <= z_q[i] + WIDTH'(atan_lut(i, WIDTH));
        if (i < ITER - 1) y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
      end else begin
        x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
        z_q[i+1] <= z_q[i] - WIDTH'(atan_lut(i, WIDTH));
        if (i < ITER - 1) y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
      end
    end
    zo  <= z_q[ITER];
    mag <= $unsigned(x_q[ITER]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      stb_out <= 1'b0;
    end else begin
      vld_q   <= {vld_q[ITER-1:0], stb_in};
      stb_out <= vld_q[ITER];
    end
  end

endmodule

// File: rtl/fm_demodulator.sv
// FM demodulator: CORDIC phase, carrier-removing phase differentiator with gain and
// saturation, integrate-and-dump decimator. Optional squelch with `FM_DEMOD_SQUELCH_EN.
module fm_demodulator
  import fm_demodulator_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FS_IN       = DEF_FS_IN,
  parameter int FS_OUT      = DEF_FS_OUT,
  parameter int FC_IN       = DEF_FC_IN,
  parameter int K           = DEF_K,
  parameter int ITER        = WIDTH,
  parameter int SQUELCH_THR = DEF_SQUELCH_THR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] data_in_i,
  input  logic signed [WIDTH-1:0] data_in_q,
  input  logic                    stb_in,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    stb_out,
  output logic                    squelch_o
);

  localparam int R      = FS_IN / FS_OUT;
  localparam int LOG_R  = clog2_ceil(R);
  localparam int CNT_W  = (LOG_R > 0) ? LOG_R : 1;
  localparam int ACC_W  = WIDTH + LOG_R;
  localparam int GSHIFT = clog2_ceil(FS_IN / K) - 2;
  localparam int DW     = WIDTH + GSHIFT;
  localparam logic [WIDTH-1:0] WC = WIDTH'((longint'(FC_IN) << WIDTH) / FS_IN);
  localparam logic signed [DW-1:0] D_MAX = DW'((longint'(1) << (WIDTH - 1)) - 1);
  localparam logic signed [DW-1:0] D_MIN = -DW'(longint'(1) << (WIDTH - 1));

  logic [WIDTH-1:0] phase;
  logic             phase_vld;

`ifdef FM_DEMOD_SQUELCH_EN
  logic [WIDTH+1:0] mag;

  cordic_vector #(.WIDTH(WIDTH), .ITER(ITER)) u_cordic (
    .clk     (clk),
    .rst_n   (rst_n),
    .xi      (data_in_i),
    .yi      (data_in_q),
    .stb_in  (stb_in),
    .zo      (phase),
    .mag     (mag),
    .stb_out (phase_vld)
  );
`else
  cordic_vector #(.WIDTH(WIDTH), .ITER(ITER)) u_cordic (
    .clk     (clk),
    .rst_n   (rst_n),
    .xi      (data_in_i),
    .yi      (data_in_q),
    .stb_in  (stb_in),
    .zo      (phase),
    .mag     (),
    .stb_out (phase_vld)
  );
`endif

  // Differentiator: the modulo-2^WIDTH subtraction unwraps the phase for free
  logic                    have_prev;
  logic [WIDTH-1:0]        phase_prev;
  logic [WIDTH-1:0]        dphi;
  logic signed [DW-1:0]    d_wide;
  logic signed [WIDTH-1:0] d_sat;
  logic signed [WIDTH-1:0] d;
  logic                    d_vld;

  assign dphi   = phase - phase_prev - WC;
  assign d_wide = DW'(signed'(dphi)) <<< GSHIFT;

  // NOTE: every path assigns d_sat, so this combinational block cannot infer a latch.
  always_comb begin
    d_sat = WIDTH'(d_wide);
    if (d_wide > D_MAX)      d_sat = WIDTH'(D_MAX);
    else if (d_wide < D_MIN) d_sat = WIDTH'(D_MIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_prev  <= 1'b0;
      phase_prev <= '0;
      d_vld      <= 1'b0;
      d          <= '0;
    end else begin
      // NOTE: non-blocking assignments here so phase_prev is read as its old value this cycle.
      d_vld <= phase_vld & have_prev;
      if (phase_vld) begin
        have_prev  <= 1'b1;
        phase_prev <= phase;
        d          <= d_sat;
      end
    end
  end

  // Squelch: per-window weak-signal flag; quiet forces the dumped sample to zero
  logic quiet;

`ifdef FM_DEMOD_SQUELCH_EN
  logic d_low;
  logic window_low;

  always_ff @(posedge clk) begin
    if (!rst_n) d_low <= 1'b0;
    else if (phase_vld) d_low <= (mag < (WIDTH+2)'(SQUELCH_THR));
  end

  assign quiet = window_low | d_low;
`else
  assign quiet     = 1'b0;
  assign squelch_o = 1'b0;
`endif

  // Integrate-and-dump decimator; gain R/2^LOG_R is left uncompensated
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_final;
  logic        [CNT_W-1:0] cnt;
  logic                    dump;

  assign acc_final = acc + ACC_W'(d);
  assign dump      = d_vld && (cnt == CNT_W'(R - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      data_out <= '0;
      stb_out  <= 1'b0;
    end else begin
      stb_out <= 1'b0;
      if (dump) begin
        acc      <= '0;
        cnt      <= '0;
        stb_out  <= 1'b1;
        data_out <= quiet ? '0 : WIDTH'(acc_final >>> LOG_R);
      end else if (d_vld) begin
        acc <= acc_final;
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef FM_DEMOD_SQUELCH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_low <= 1'b0;
      squelch_o  <= 1'b0;
    end else if (dump) begin
      window_low <= 1'b0;
      squelch_o  <= quiet;
    end else if (d_vld) begin
      window_low <= quiet;
    end
  end
`endif

endmodule

// File: tb/tb_fm_demodulator.sv
// Self-checking bench for fm_demodulator: tone table through a scoreboard, plus reset-mid-window
// and (with FM_DEMOD_SQUELCH_EN) squelch sequences.
module tb_fm_demodulator;

  localparam int W      = 16;
  localparam int R      = 100;
  localparam int ITER   = 16;
  localparam int LAT    = ITER + 2;
  localparam int PERIOD = 10;
  localparam real TWO_PI = 6.283185307179586;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] data_in_i = '0;
  logic signed [W-1:0] data_in_q = '0;
  logic                stb_in = 1'b0;
  logic signed [W-1:0] data_out;
  logic                stb_out;
  logic                squelch_o;

  fm_demodulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in_i (data_in_i),
    .data_in_q (data_in_q),
    .stb_in    (stb_in),
    .data_out  (data_out),
    .stb_out   (stb_out),
    .squelch_o (squelch_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int exp;
    int tol;
    bit sq;
    int cyc;
  } exp_t;

  typedef struct {
    string name;
    int    step;
    int    amp;
    int    exp;
    int    tol;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;
  int   phase = 0;
  int   nsamp = 0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One I/Q sample; when it completes a window the expected dump is queued
  task automatic send(input int step, input int amp, input int exp, input int tol, input bit sq);
    real ang, ri, rq;
    @(posedge clk); #1;
    ang = TWO_PI * real'(phase) / 65536.0;
    ri  = real'(amp) * $cos(ang);
    rq  = real'(amp) * $sin(ang);
    data_in_i = W'($rtoi(ri >= 0.0 ? ri + 0.5 : ri - 0.5));
    data_in_q = W'($rtoi(rq >= 0.0 ? rq + 0.5 : rq - 0.5));
    stb_in = 1'b1;
    nsamp++;
    if (nsamp > 1 && (nsamp - 1) % R == 0) sb.push_back('{exp, tol, sq, cyc});
    phase = (phase + step) & 32'hffff;
    @(posedge clk); #1;
    stb_in = 1'b0;
    repeat (PERIOD - 2) @(posedge clk);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    stb_in = 1'b1;
    @(posedge clk); #1;
    stb_in = 1'b0;
    check({name, "_rst_data_out"}, data_out == 0, int'(data_out), 0);
    check({name, "_rst_stb_out"}, stb_out == 1'b0, int'(stb_out), 0);
    check({name, "_rst_squelch"}, squelch_o == 1'b0, int'(squelch_o), 0);
    sb.delete();
    nsamp = 0;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4 * LAT) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, sb.size() == 0, sb.size(), 0);
  endtask

  // Scoreboard consumer: value within tolerance, squelch flag and strobe latency
  always @(negedge clk) begin
    exp_t e;
    int   diff;
    if (stb_out) begin
      if (sb.size() == 0) begin
        check("unexpected_stb_out", 1'b0, int'(data_out), 0);
      end else begin
        e    = sb.pop_front();
        diff = int'(data_out) - e.exp;
        check("data_out", diff <= e.tol && diff >= -e.tol, int'(data_out), e.exp);
        check("squelch_o", squelch_o == e.sq, int'(squelch_o), int'(e.sq));
        check("stb_latency", cyc - e.cyc == LAT + 2, cyc - e.cyc, LAT + 2);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"carrier",        13653, 30000,      0, 4};
    vecs[1] = '{"plus50k",        14336, 30000,   4268, 8};
    vecs[2] = '{"minus100k_wrap", 12288, 30000,  -8532, 8};
    vecs[3] = '{"plus25k",        13994, 30000,   2131, 8};
    vecs[4] = '{"plus600k_sat",   21845, 30000,  25599, 0};
    vecs[5] = '{"minus600k_sat",   5461, 30000, -25600, 0};

    repeat (3) @(posedge clk);
    #1;
    check("por_data_out", data_out == 0, int'(data_out), 0);
    check("por_stb_out", stb_out == 1'b0, int'(stb_out), 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      do_reset(vecs[v].name);
      phase = int'($urandom_range(0, 65535));
      for (int s = 0; s < 3 * R + 1; s++) send(vecs[v].step, vecs[v].amp, vecs[v].exp, vecs[v].tol, 1'b0);
      drain(vecs[v].name);
    end

    // Reset mid-window: partial window and in-flight samples are discarded
    do_reset("midrst");
    for (int s = 0; s < R + 1 + 50; s++) send(14336, 30000, 4268, 8, 1'b0);
    drain("midrst_pre");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_data_out", data_out == 0, int'(data_out), 0);
    check("midrst_stb_out", stb_out == 1'b0, int'(stb_out), 0);
    nsamp = 0;
    for (int s = 0; s < R; s++) send(14336, 30000, 4268, 8, 1'b0);
    repeat (2 * LAT) @(posedge clk);
    check("midrst_no_early_out", sb.size() == 0, sb.size(), 0);
    send(14336, 30000, 4268, 8, 1'b0);
    drain("midrst_post");

`ifdef FM_DEMOD_SQUELCH_EN
    do_reset("squelch");
    for (int s = 0; s < R; s++) send(14336, 100, 0, 0, 1'b1);
    send(14336, 30000, 0, 0, 1'b1);
    for (int s = 0; s < R; s++) send(14336, 30000, 4268, 8, 1'b0);
    drain("squelch");
`endif

    repeat (2 * LAT) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
